// File: rtl/fetch_queue_unit_if.sv
// fetch_queue_unit_if: redirect, instruction-memory and decode handshake bundle of the fetch stage.
// master is the fetch unit itself; slave is the surrounding pipeline / memory.
interface fetch_queue_unit_if #(parameter int XLEN = 32);
   logic            pc_src_exec;
   logic [XLEN-1:0] pc_target_exec;
   logic            imem_req_valid;
   logic            imem_req_ready;
   logic [XLEN-1:0] imem_addr;
   logic            imem_rsp_valid;
   logic [XLEN-1:0] imem_rsp_data;
   logic [XLEN-1:0] instr_decode;
   logic [XLEN-1:0] pc_decode;
   logic [XLEN-1:0] next_pc_decode;
   logic            valid_decode;
   logic            ready_decode;
   modport master (
      input  pc_src_exec, pc_target_exec, imem_req_ready, imem_rsp_valid, imem_rsp_data, ready_decode,
      output imem_req_valid, imem_addr, instr_decode, pc_decode, next_pc_decode, valid_decode
   );
   modport slave (
      output pc_src_exec, pc_target_exec, imem_req_ready, imem_rsp_valid, imem_rsp_data, ready_decode,
      input  imem_req_valid, imem_addr, instr_decode, pc_decode, next_pc_decode, valid_decode
   );
endinterface

// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: RV32 fetch stage, one outstanding imem request, decoupling queue to decode.
// Redirects flush the queue and turn an in-flight request into a dropped one.
module fetch_queue_unit #(
   parameter int              XLEN       = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int              FIFO_DEPTH = 4
) (
   input logic                 clk,
   input logic                 rst_n,
   fetch_queue_unit_if.master  bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;
   state_t          r_state;
   logic [XLEN-1:0] r_fetch_pc;
   logic [XLEN-1:0] r_req_pc;
   logic [XLEN-1:0] r_pc_q  [FIFO_DEPTH];
   logic [XLEN-1:0] r_npc_q [FIFO_DEPTH];
   logic [XLEN-1:0] r_ins_q [FIFO_DEPTH];
   logic [AW-1:0]   r_rd;
   logic [AW-1:0]   r_wr;
   logic [CW-1:0]   r_count;
   logic            w_req_valid;
   logic            w_accept;
   logic            w_rsp;
   logic            w_push;
   logic            w_pop;
   // issue needs a free slot now; a pop this cycle does not count as space
   assign w_req_valid = rst_n && (r_state == IDLE) && (r_count < CW'(FIFO_DEPTH)) && !bus.pc_src_exec;
   assign w_accept    = w_req_valid && bus.imem_req_ready;
   assign w_rsp       = bus.imem_rsp_valid && (r_state != IDLE);
   assign w_push      = w_rsp && (r_state == WAIT) && !bus.pc_src_exec;
   assign w_pop       = (r_count != '0) && bus.ready_decode && !bus.pc_src_exec;
   assign bus.imem_req_valid = w_req_valid;
   assign bus.imem_addr      = r_fetch_pc;
   assign bus.valid_decode   = (r_count != '0);
   assign bus.pc_decode      = r_pc_q[r_rd];
   assign bus.next_pc_decode = r_npc_q[r_rd];
   assign bus.instr_decode   = r_ins_q[r_rd];
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_fetch_pc <= RESET_PC;
         r_req_pc   <= '0;
         r_rd       <= '0;
         r_wr       <= '0;
         r_count    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_pc_q[i]  <= '0;
            r_npc_q[i] <= '0;
            r_ins_q[i] <= '0;
         end
      end else if (bus.pc_src_exec) begin
         r_fetch_pc <= bus.pc_target_exec & ~XLEN'(3);
         r_rd       <= '0;
         r_wr       <= '0;
         r_count    <= '0;
         // an in-flight request that has not answered yet must be swallowed later
         r_state    <= (r_state == IDLE || bus.imem_rsp_valid) ? IDLE : DROP;
      end else begin
         if (w_accept) begin
            r_state    <= WAIT;
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + XLEN'(4);
         end else if (w_rsp) begin
            r_state <= IDLE;
         end
         if (w_push) begin
            r_pc_q[r_wr]  <= r_req_pc;
            r_npc_q[r_wr] <= r_req_pc + XLEN'(4);
            r_ins_q[r_wr] <= bus.imem_rsp_data;
            r_wr          <= r_wr + 1'b1;
         end
         if (w_pop)
            r_rd <= r_rd + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit: directed table, hand-written corner sequences and a randomized
// run against a queue-based model of the fetch stage.
module tb_fetch_queue_unit;
   localparam int D = 4;
   typedef struct {
      logic [31:0] rr, rsp, data, rd, redir, tgt;
      logic [31:0] erv, eaddr, evld, epc, eins;
   } vec_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   vec_t tbl[$];
   logic [31:0] qpc[$];
   logic [31:0] qins[$];
   logic [31:0] m_pc, m_req_pc;
   logic        m_out, m_keep, r_rr, r_rsp, r_rd, r_redir, e_rv;
   logic [31:0] r_data, r_tgt;
   fetch_queue_unit_if #(.XLEN(32)) b ();
   fetch_queue_unit_if #(.XLEN(32)) b2 ();
   fetch_queue_unit #(.XLEN(32), .RESET_PC(32'h0), .FIFO_DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .bus(b.master));
   fetch_queue_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(D)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(b2.master));
   always #5 clk = ~clk;
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask
   task automatic drive(input logic [31:0] rr, rsp, data, rd, redir, tgt);
      @(negedge clk);
      b.imem_req_ready = rr[0];
      b.imem_rsp_valid = rsp[0];
      b.imem_rsp_data  = data;
      b.ready_decode   = rd[0];
      b.pc_src_exec    = redir[0];
      b.pc_target_exec = tgt;
      #1;
   endtask
   task automatic drv2(input logic [31:0] rr, rsp, data, rd);
      @(negedge clk);
      b2.imem_req_ready = rr[0];
      b2.imem_rsp_valid = rsp[0];
      b2.imem_rsp_data  = data;
      b2.ready_decode   = rd[0];
      #1;
   endtask
   task automatic v(input logic [31:0] rr, rsp, data, rd, redir, tgt, erv, eaddr, evld, epc, eins);
      tbl.push_back('{rr, rsp, data, rd, redir, tgt, erv, eaddr, evld, epc, eins});
   endtask
   initial begin
      {b.imem_req_ready, b.imem_rsp_valid, b.ready_decode, b.pc_src_exec} = '0;
      b.imem_rsp_data = '0;
      b.pc_target_exec = '0;
      {b2.imem_req_ready, b2.imem_rsp_valid, b2.ready_decode, b2.pc_src_exec} = '0;
      b2.imem_rsp_data = '0;
      b2.pc_target_exec = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_rv", b.imem_req_valid, 0);
      chk("rst_vld", b.valid_decode, 0);
      chk("rst_addr", b.imem_addr, 0);
      chk("rst_pc", b.pc_decode, 0);
      chk("rst_npc", b.next_pc_decode, 0);
      chk("rst_ins", b.instr_decode, 0);
      chk("rst_addr2", b2.imem_addr, 32'hFFFF_FFF8);
      @(negedge clk);
      rst_n = 1'b1;
      // sequential fetch, redirect while waiting, redirect colliding with response and pop
      v(1, 0, 0,       1, 0, 0,      1, 'h0,   0, 0,     0);
      v(1, 1, 'hA0,    1, 0, 0,      0, 'h4,   0, 0,     0);
      v(1, 0, 0,       1, 0, 0,      1, 'h4,   1, 'h0,   'hA0);
      v(1, 1, 'hA1,    1, 0, 0,      0, 'h8,   0, 0,     0);
      v(1, 0, 0,       1, 0, 0,      1, 'h8,   1, 'h4,   'hA1);
      v(1, 1, 'hA2,    1, 0, 0,      0, 'hC,   0, 0,     0);
      v(1, 0, 0,       1, 0, 0,      1, 'hC,   1, 'h8,   'hA2);
      v(1, 0, 0,       1, 1, 'h100,  0, 'h10,  0, 0,     0);
      v(1, 0, 0,       1, 0, 0,      0, 'h100, 0, 0,     0);
      v(1, 0, 0,       1, 0, 0,      0, 'h100, 0, 0,     0);
      v(1, 1, 'hDEAD,  1, 0, 0,      0, 'h100, 0, 0,     0);
      v(1, 0, 0,       1, 0, 0,      1, 'h100, 0, 0,     0);
      v(1, 1, 'hB0,    1, 0, 0,      0, 'h104, 0, 0,     0);
      v(1, 0, 0,       0, 0, 0,      1, 'h104, 1, 'h100, 'hB0);
      v(1, 1, 'hC0,    1, 1, 'h203,  0, 'h108, 1, 'h100, 'hB0);
      v(1, 0, 0,       1, 0, 0,      1, 'h200, 0, 0,     0);
      v(1, 1, 'hD0,    1, 0, 0,      0, 'h204, 0, 0,     0);
      v(1, 0, 0,       1, 0, 0,      1, 'h204, 1, 'h200, 'hD0);
      v(1, 1, 'hD1,    1, 0, 0,      0, 'h208, 0, 0,     0);
      v(0, 0, 0,       1, 0, 0,      1, 'h208, 1, 'h204, 'hD1);
      foreach (tbl[i]) begin
         drive(tbl[i].rr, tbl[i].rsp, tbl[i].data, tbl[i].rd, tbl[i].redir, tbl[i].tgt);
         chk($sformatf("tbl%0d_rv", i), b.imem_req_valid, tbl[i].erv);
         chk($sformatf("tbl%0d_addr", i), b.imem_addr, tbl[i].eaddr);
         chk($sformatf("tbl%0d_vld", i), b.valid_decode, tbl[i].evld);
         if (tbl[i].evld[0]) begin
            chk($sformatf("tbl%0d_pc", i), b.pc_decode, tbl[i].epc);
            chk($sformatf("tbl%0d_npc", i), b.next_pc_decode, tbl[i].epc + 4);
            chk($sformatf("tbl%0d_ins", i), b.instr_decode, tbl[i].eins);
         end
      end
      // reset while a request is outstanding and two entries are queued
      drive(1, 0, 0, 0, 0, 0);
      chk("t6_addr", b.imem_addr, 'h208);
      drive(0, 1, 'hE0, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      drive(0, 1, 'hE1, 0, 0, 0);
      drive(1, 0, 0, 0, 0, 0);
      chk("t6_pre_head", b.pc_decode, 'h208);
      drive(0, 0, 0, 0, 0, 0);
      chk("t6_pre_vld", b.valid_decode, 1);
      chk("t6_pre_rv", b.imem_req_valid, 0);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_vld", b.valid_decode, 0);
      chk("t6_rst_rv", b.imem_req_valid, 0);
      chk("t6_rst_addr", b.imem_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("t6_rel_addr", b.imem_addr, 0);
      chk("t6_rel_rv", b.imem_req_valid, 1);
      // stalled decode fills the queue, then drains in order
      for (int i = 0; i < D; i++) begin
         drive(1, 0, 0, 0, 0, 0);
         chk("t2_fill_rv", b.imem_req_valid, 1);
         chk("t2_fill_addr", b.imem_addr, 4 * i);
         drive(0, 1, 'hC000 + i, 0, 0, 0);
      end
      repeat (2) begin
         drive(1, 0, 0, 0, 0, 0);
         chk("t2_full_rv", b.imem_req_valid, 0);
         chk("t2_full_vld", b.valid_decode, 1);
      end
      for (int i = 0; i < D; i++) begin
         drive(0, 0, 0, 1, 0, 0);
         chk("t2_drain_rv", b.imem_req_valid, (i != 0) ? 1 : 0);
         chk("t2_drain_pc", b.pc_decode, 4 * i);
         chk("t2_drain_ins", b.instr_decode, 'hC000 + i);
      end
      drive(0, 0, 0, 0, 0, 0);
      chk("t2_empty_vld", b.valid_decode, 0);
      chk("t2_resume_addr", b.imem_addr, 4 * D);
      chk("t2_resume_rv", b.imem_req_valid, 1);
      // PC wrap-around on the second instance
      drv2(1, 0, 0, 0);
      chk("t5_addr0", b2.imem_addr, 32'hFFFF_FFF8);
      drv2(0, 1, 'h11, 0);
      chk("t5_addr1", b2.imem_addr, 32'hFFFF_FFFC);
      drv2(1, 0, 0, 0);
      chk("t5_head0_pc", b2.pc_decode, 32'hFFFF_FFF8);
      chk("t5_head0_npc", b2.next_pc_decode, 32'hFFFF_FFFC);
      drv2(0, 1, 'h22, 0);
      chk("t5_addr2", b2.imem_addr, 0);
      drv2(0, 0, 0, 1);
      chk("t5_pop0_pc", b2.pc_decode, 32'hFFFF_FFF8);
      drv2(0, 0, 0, 1);
      chk("t5_head1_pc", b2.pc_decode, 32'hFFFF_FFFC);
      chk("t5_head1_npc", b2.next_pc_decode, 0);
      chk("t5_head1_ins", b2.instr_decode, 'h22);
      drv2(0, 0, 0, 0);
      // randomized traffic against the queue model
      m_pc = 4 * D;
      m_out = 1'b0;
      m_keep = 1'b0;
      m_req_pc = '0;
      for (int n = 0; n < 2000; n++) begin
         r_rr    = ($urandom_range(0, 3) != 0);
         r_rsp   = m_out && ($urandom_range(0, 2) == 0);
         r_data  = $urandom;
         r_rd    = ($urandom_range(0, 1) != 0);
         r_redir = ($urandom_range(0, 15) == 0);
         r_tgt   = $urandom;
         drive({31'b0, r_rr}, {31'b0, r_rsp}, r_data, {31'b0, r_rd}, {31'b0, r_redir}, r_tgt);
         e_rv = !m_out && (qpc.size() < D) && !r_redir;
         chk("rnd_rv", b.imem_req_valid, {31'b0, e_rv});
         chk("rnd_addr", b.imem_addr, m_pc);
         chk("rnd_vld", b.valid_decode, (qpc.size() != 0) ? 1 : 0);
         if (qpc.size() != 0) begin
            chk("rnd_pc", b.pc_decode, qpc[0]);
            chk("rnd_npc", b.next_pc_decode, qpc[0] + 4);
            chk("rnd_ins", b.instr_decode, qins[0]);
         end
         if (r_redir) begin
            qpc.delete();
            qins.delete();
            m_pc = {r_tgt[31:2], 2'b00};
            if (r_rsp) m_out = 1'b0;
            m_keep = 1'b0;
         end else begin
            if (r_rd && qpc.size() != 0) begin
               void'(qpc.pop_front());
               void'(qins.pop_front());
            end
            if (r_rsp) begin
               if (m_keep) begin
                  qpc.push_back(m_req_pc);
                  qins.push_back(r_data);
               end
               m_out = 1'b0;
            end else if (e_rv && r_rr) begin
               m_out = 1'b1;
               m_keep = 1'b1;
               m_req_pc = m_pc;
               m_pc = m_pc + 4;
            end
         end
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
